// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port, word-addressed data memory between
// port 0 (CPU load/store) and port 1 (debug/DMA loader).
// - Combinational grant, fixed priority to port 0, aging counter lets port 1
//   win after MAX_STALL consecutive denied cycles.
// - Read data (1-cycle memory latency) is steered back to the issuing port.
// Optional feature macro: DMEM_ARB_BOUNDS_EN (out-of-range accesses are
// granted but not forwarded, and answered with a one-cycle err pulse).
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STALL  = 4,
  parameter int MEM_WORDS  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  localparam logic [3:0] STALL_LIM = 4'(MAX_STALL);

  // Reject configurations the 4-bit aging counter or bounds check cannot honour.
  if (MAX_STALL < 1 || MAX_STALL > 15 || MEM_WORDS < 1) begin : g_param_chk
    $error("dmem_arbiter: MAX_STALL must be 1..15 and MEM_WORDS >= 1");
  end

  logic                  m0_win, m1_win, win;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wd;
  logic                  oob;
  logic [3:0]            starve_cnt;
  logic                  rd_pend;
  logic                  rd_id;

  // Arbitration: aged port 1 first, then port 0, then port 1; nothing in reset.
  always_comb begin
    m0_win = 1'b0;
    m1_win = 1'b0;
    if (!rst) begin
      if (m1_req && (starve_cnt == STALL_LIM)) m1_win = 1'b1;
      else if (m0_req)                         m0_win = 1'b1;
      else if (m1_req)                         m1_win = 1'b1;
    end
  end

  assign win    = m0_win | m1_win;
  assign m0_gnt = m0_win;
  assign m1_gnt = m1_win;

  // Winner's request fields; port 0 fields when nobody wins (masked below).
  always_comb begin
    win_we   = m0_we;
    win_addr = m0_addr;
    win_wd   = m0_wdata;
    if (m1_win) begin
      win_we   = m1_we;
      win_addr = m1_addr;
      win_wd   = m1_wdata;
    end
  end

`ifdef DMEM_ARB_BOUNDS_EN
  localparam logic [ADDR_WIDTH-3:0] WORD_LIM = (ADDR_WIDTH-2)'(MEM_WORDS);
  // Word index beyond the memory: grant, but keep it off the memory bus.
  assign oob = win_addr[ADDR_WIDTH-1:2] >= WORD_LIM;
`else
  assign oob = 1'b0;
`endif

  // Memory bus: only a forwarded winner drives it, otherwise all zero.
  always_comb begin
    mem_we = win & win_we & ~oob;
    mem_a  = (win && !oob) ? win_addr : '0;
    mem_wd = win ? win_wd : '0;
  end

  // Aging counter and read-return tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      rd_pend    <= 1'b0;
      rd_id      <= 1'b0;
    end else begin
      rd_pend <= win & ~win_we & ~oob;
      rd_id   <= m1_win;
      if (m1_req && !m1_win)
        starve_cnt <= (starve_cnt == STALL_LIM) ? starve_cnt : starve_cnt + 4'd1;
      else
        starve_cnt <= '0;
    end
  end

  // Steer registered memory data to the port that issued the read.
  always_comb begin
    m0_rvalid = rd_pend & ~rd_id;
    m1_rvalid = rd_pend &  rd_id;
    m0_rdata  = m0_rvalid ? mem_rd : '0;
    m1_rdata  = m1_rvalid ? mem_rd : '0;
  end

`ifdef DMEM_ARB_BOUNDS_EN
  logic err_pend;

  // Remember a rejected access so its port sees a one-cycle error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_pend <= 1'b0;
    else     err_pend <= win & oob;
  end

  assign m0_err = err_pend & ~rd_id;
  assign m1_err = err_pend &  rd_id;
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of per-cycle vectors plus hand-written
// sequences for reset-during-read and (when enabled) the bounds check.
// The memory is modelled here as a 64-word registered-read RAM whose word i
// is reloaded to 0xA000_0000+i while rst is high.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  logic [DW-1:0] mem [64];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STALL(4), .MEM_WORDS(64)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Registered-read RAM; word index from byte address bits [7:2].
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      mem_rd <= '0;
    end else begin
      if (mem_we) mem[mem_a[7:2]] <= mem_wd;
      mem_rd <= mem[mem_a[7:2]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        r0, w0; logic [31:0] a0, d0;
    logic        r1, w1; logic [31:0] a1, d1;
    logic        g0, g1, mwe; logic [31:0] ma, mwd;
    logic        v0; logic [31:0] rd0;
    logic        v1; logic [31:0] rd1;
  } vec_t;

  function automatic vec_t mk(
    input logic r0, w0, input logic [31:0] a0, d0,
    input logic r1, w1, input logic [31:0] a1, d1,
    input logic g0, g1, mwe, input logic [31:0] ma, mwd,
    input logic v0, input logic [31:0] rd0,
    input logic v1, input logic [31:0] rd1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.ma = ma; v.mwd = mwd;
    v.v0 = v0; v.rd0 = rd0; v.v1 = v1; v.rd1 = rd1;
    return v;
  endfunction

  task automatic drive(input logic r0, w0, input logic [31:0] a0, d0,
                       input logic r1, w1, input logic [31:0] a1, d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic chk_all(input string p, input vec_t v);
    chk({p, " m0_gnt"},    32'(m0_gnt),    32'(v.g0));
    chk({p, " m1_gnt"},    32'(m1_gnt),    32'(v.g1));
    chk({p, " mem_we"},    32'(mem_we),    32'(v.mwe));
    chk({p, " mem_a"},     mem_a,          v.ma);
    chk({p, " mem_wd"},    mem_wd,         v.mwd);
    chk({p, " m0_rvalid"}, 32'(m0_rvalid), 32'(v.v0));
    chk({p, " m0_rdata"},  m0_rdata,       v.rd0);
    chk({p, " m1_rvalid"}, 32'(m1_rvalid), 32'(v.v1));
    chk({p, " m1_rdata"},  m1_rdata,       v.rd1);
    chk({p, " m0_err"},    32'(m0_err),    32'd0);
    chk({p, " m1_err"},    32'(m1_err),    32'd0);
  endtask

  localparam logic [31:0] W0 = 32'hA000_0000, W1 = 32'hA000_0001;
  localparam logic [31:0] W3 = 32'hA000_0003, W4 = 32'hA000_0004;
  localparam logic [31:0] DB = 32'hDEAD_BEEF, PAT = 32'h1234_5678;

  vec_t tbl [23];

  initial begin
    // Per-cycle vectors: inputs, then expected gnt/mem bus and responses to
    // the previous cycle's read.
    tbl[0]  = mk(1,1,32'h08,DB, 0,0,0,0,       1,0,1,32'h08,DB, 0,0, 0,0);
    tbl[1]  = mk(1,0,32'h08,0,  0,0,0,0,       1,0,0,32'h08,0,  0,0, 0,0);
    tbl[2]  = mk(0,0,0,0,       0,0,0,0,       0,0,0,0,0,       1,DB, 0,0);
    tbl[3]  = mk(1,0,32'h00,0,  0,0,0,0,       1,0,0,32'h00,0,  0,0, 0,0);
    tbl[4]  = mk(0,0,0,0,       1,0,32'h04,0,  0,1,0,32'h04,0,  1,W0, 0,0);
    tbl[5]  = mk(1,0,32'h00,0,  0,0,0,0,       1,0,0,32'h00,0,  0,0, 1,W1);
    tbl[6]  = mk(0,0,0,0,       1,0,32'h04,0,  0,1,0,32'h04,0,  1,W0, 0,0);
    tbl[7]  = mk(0,0,0,0,       0,0,0,0,       0,0,0,0,0,       0,0, 1,W1);
    // Contention: m0 reads 0x0C, m1 reads 0x10 every cycle.
    tbl[8]  = mk(1,0,32'h0C,0,  1,0,32'h10,0,  1,0,0,32'h0C,0,  0,0, 0,0);
    for (int i = 9; i <= 11; i++)
      tbl[i] = mk(1,0,32'h0C,0, 1,0,32'h10,0,  1,0,0,32'h0C,0,  1,W3, 0,0);
    tbl[12] = mk(1,0,32'h0C,0,  1,0,32'h10,0,  0,1,0,32'h10,0,  1,W3, 0,0);
    tbl[13] = mk(1,0,32'h0C,0,  1,0,32'h10,0,  1,0,0,32'h0C,0,  0,0, 1,W4);
    for (int i = 14; i <= 16; i++)
      tbl[i] = mk(1,0,32'h0C,0, 1,0,32'h10,0,  1,0,0,32'h0C,0,  1,W3, 0,0);
    tbl[17] = mk(1,0,32'h0C,0,  1,0,32'h10,0,  0,1,0,32'h10,0,  1,W3, 0,0);
    tbl[18] = mk(0,0,0,0,       0,0,0,0,       0,0,0,0,0,       0,0, 1,W4);
    tbl[19] = mk(0,0,0,0,       0,0,0,0,       0,0,0,0,0,       0,0, 0,0);
    // Port 1 write, then port 0 reads it back the next cycle.
    tbl[20] = mk(0,0,0,0,       1,1,32'h14,PAT, 0,1,1,32'h14,PAT, 0,0, 0,0);
    tbl[21] = mk(1,0,32'h14,0,  0,0,0,0,       1,0,0,32'h14,0,  0,0, 0,0);
    tbl[22] = mk(0,0,0,0,       0,0,0,0,       0,0,0,0,0,       1,PAT, 0,0);

    // Reset state, with both ports requesting writes.
    drive(1,1,32'h08,DB, 1,1,32'h0C,DB);
    repeat (2) @(negedge clk);
    #1;
    chk_all("reset", mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0, 0,0));
    drive(0,0,0,0, 0,0,0,0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      #1;
      chk_all($sformatf("row%0d", i), tbl[i]);
    end

    // Read granted, then reset asserted before the edge: the read is dropped.
    @(negedge clk);
    drive(1,0,32'h00,0, 0,0,0,0);
    #1 chk("rstmid gnt", 32'(m0_gnt), 32'd1);
    #1 rst = 1'b1;
    m0_we = 1'b1;
    #1;
    chk("rstmid gnt_in_rst", 32'(m0_gnt), 32'd0);
    chk("rstmid mem_we",     32'(mem_we), 32'd0);
    chk("rstmid mem_a",      mem_a,       32'd0);
    @(negedge clk);
    drive(0,0,0,0, 0,0,0,0);
    #1;
    chk("rstmid rvalid0", 32'(m0_rvalid), 32'd0);
    chk("rstmid rvalid1", 32'(m1_rvalid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rstpost rvalid0", 32'(m0_rvalid), 32'd0);
    chk("rstpost rvalid1", 32'(m1_rvalid), 32'd0);
    // Normal operation resumes.
    @(negedge clk);
    drive(0,0,0,0, 1,0,32'h04,0);
    #1 chk("resume gnt1", 32'(m1_gnt), 32'd1);
    @(negedge clk);
    drive(0,0,0,0, 0,0,0,0);
    #1;
    chk("resume rvalid1", 32'(m1_rvalid), 32'd1);
    chk("resume rdata1",  m1_rdata,       W1);

`ifdef DMEM_ARB_BOUNDS_EN
    // Out-of-range write: granted, not forwarded, error next cycle.
    @(negedge clk);
    drive(0,0,0,0, 1,1,32'h100,32'h5555_5555);
    #1;
    chk("oob gnt1",   32'(m1_gnt), 32'd1);
    chk("oob mem_we", 32'(mem_we), 32'd0);
    chk("oob mem_a",  mem_a,       32'd0);
    @(negedge clk);
    drive(1,0,32'h00,0, 0,0,0,0);
    #1;
    chk("oob err1",    32'(m1_err),    32'd1);
    chk("oob err0",    32'(m0_err),    32'd0);
    chk("oob rvalid1", 32'(m1_rvalid), 32'd0);
    chk("oob rdata1",  m1_rdata,       32'd0);
    @(negedge clk);
    drive(0,0,0,0, 0,0,0,0);
    #1;
    chk("oob err1_clr", 32'(m1_err),    32'd0);
    chk("oob rvalid0",  32'(m0_rvalid), 32'd1);
    chk("oob word0",    m0_rdata,       W0);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, word-addressed data memory between two requesters: port 0 (CPU load/store stage) and port 1 (debug/DMA loader).
- Selects at most one access per cycle and drives the memory's write enable, address and write data.
- Routes the memory's one-cycle-latency read data back to the requester that issued the read.
- Fixed priority to port 0, with an aging counter so port 1 cannot starve.

Parameters:
- ADDR_WIDTH, 32, byte-address width of both requester ports and the memory address.
- DATA_WIDTH, 32, data width.
- MAX_STALL, 4, consecutive denied cycles after which port 1 wins priority (range 1..15).
- MEM_WORDS, 64, memory depth in words; used only by the optional bounds check.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  port 0 access request.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  ADDR_WIDTH  port 0 byte address.
- m0_wdata  in  DATA_WIDTH  port 0 write data.
- m0_gnt  out  1  port 0 access accepted this cycle.
- m0_rvalid  out  1  port 0 read data valid.
- m0_rdata  out  DATA_WIDTH  port 0 read data.
- m0_err  out  1  port 0 error response (optional feature only).
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as port 0, for port 1.
- mem_we  out  1  memory write enable.
- mem_a  out  ADDR_WIDTH  memory byte address.
- mem_wd  out  DATA_WIDTH  memory write data.
- mem_rd  in  DATA_WIDTH  memory read data, registered, valid one cycle after a read issue.

Behaviour:
- Grant is combinational, same cycle as the request. A request is accepted when req and gnt are both high. There is no request queue: a requester holds req and its fields stable until granted.
- Arbitration:
  - m1 wins if starve_cnt == MAX_STALL and m1_req is high.
  - Otherwise m0 wins if m0_req is high.
  - Otherwise m1 wins if m1_req is high.
  - At most one gnt is high in any cycle.
- Memory drive:
  - Winner present: mem_we = winner.we, mem_a = winner.addr, mem_wd = winner.wdata.
  - No winner: mem_we = 0, mem_a = 0, mem_wd = 0.
  - mem_we is forced to 0 while rst is high.
- Starve counter (4-bit register):
  - Increments, saturating at MAX_STALL, in each cycle where m1_req is high and m1_gnt is low.
  - Clears when m1 is granted or m1_req is low.
- Read return:
  - Pending register {rd_pend, rd_id} is loaded on every edge with {granted & !we, winner id}.
  - In the next cycle, mX_rvalid = rd_pend & (rd_id == X).
  - mX_rdata = mem_rd when mX_rvalid is high, else 0.
  - Read latency is exactly 1 cycle.
  - Back-to-back reads, including alternating ports, sustain 1 access per cycle.
- Writes complete on the granted edge and produce no response.
- A read of the address written in the previous cycle returns the new data; the memory ordering provides this.
- Reset values: rd_pend = 0, rd_id = 0, starve_cnt = 0; all rvalid/rdata/err = 0.
  - gnt and mem_* are combinational and are 0 while rst is high.
  - A read pending when rst asserts is dropped; no rvalid follows.
- Address: passed unchanged. Word select (addr/4) is done by the memory; addr[1:0] is ignored.

Optional Feature:
- Macro: DMEM_ARB_BOUNDS_EN.
- Defined:
  - A granted access with addr[ADDR_WIDTH-1:2] >= MEM_WORDS is still granted (gnt=1) but is not forwarded: mem_we = 0, mem_a = 0.
  - The cycle after the grant, mX_err = 1 for one cycle, with rvalid = 0 and rdata = 0, for both reads and writes.
- Undefined: no check; err outputs are tied to 0; out-of-range addresses pass to the memory unchanged.

Test Plan:
- Port 0 writes 0xDEADBEEF to addr 0x08, then reads 0x08 -> m0_gnt=1 both cycles; m0_rvalid=1 with m0_rdata=0xDEADBEEF exactly one cycle after the read grant; m1_rvalid stays 0.
- Port 0 and port 1 both request continuously (m1 reading addr 0x10) -> m0 granted 4 cycles; m1 granted on the 5th cycle; starve_cnt returns to 0; the pattern repeats every 5 cycles.
- Alternating reads: m0 reads 0x00, m1 reads 0x04 in consecutive cycles -> rvalid pulses alternate between ports, each carrying the correct word; no gap cycles.
- Read granted, rst asserted before the next edge -> no rvalid on either port; mem_we = 0; all outputs 0 during reset; normal operation resumes after release.
- Idle (no req) -> mem_we = 0, mem_a = 0, both gnt = 0, starve_cnt = 0.
- With DMEM_ARB_BOUNDS_EN and MEM_WORDS = 64: m1 writes addr 0x100 -> m1_gnt = 1, mem_we = 0, m1_err = 1 in the next cycle; memory contents unchanged (verified by a read of 0x00).
